// File: rtl/multi_channel_interval_timer_pkg.sv
// Register map, bit positions and address sizing shared by the interval timer
// top level and its per-channel counter.
package timer_pkg;

   localparam logic [2:0] REG_STATUS   = 3'd0;
   localparam logic [2:0] REG_CONTROL  = 3'd1;
   localparam logic [2:0] REG_PERIOD   = 3'd2;
   localparam logic [2:0] REG_SNAP     = 3'd3;
   localparam logic [2:0] REG_PRESCALE = 3'd4;

   localparam int ST_TO    = 0;
   localparam int ST_RUN   = 1;

   localparam int CT_ITO   = 0;
   localparam int CT_CONT  = 1;
   localparam int CT_START = 2;
   localparam int CT_STOP  = 3;
   localparam int CT_CHAIN = 4;

   // Word address: channel number above a 3-bit register offset.
   function automatic int addr_w(input int num_ch);
      return $clog2(num_ch) + 3;
   endfunction

endpackage

// File: rtl/multi_channel_interval_timer_channel.sv
// One timer channel: prescaler, down-counter, TO/RUN flags, snapshot register
// and the registered one-clock timeout pulse.
module timer_channel
   import timer_pkg::*;
#(
   parameter int CH_IDX         = 0,
   parameter int CNT_W          = 32,
   parameter int PRESCALE_W     = 8,
   parameter int DEFAULT_PERIOD = 39999
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  reg_sel,
   input  logic        wr_en,
   input  logic [31:0] wdata,
   input  logic        chain_in,
   output logic [31:0] rdata,
   output logic        irq,
   output logic        pulse
);

   // Width 0 keeps a 1-bit prescaler pinned at 0, so every clock is a tick.
   localparam int PW = (PRESCALE_W > 0) ? PRESCALE_W : 1;

   logic [CNT_W-1:0] cnt, period, snap;
   logic [PW-1:0]    prescale, pre_cnt, wr_prescale;
   logic             ito, cont, chain, to, run;
   logic             use_chain, pre_hit, tick, timeout_event;

   assign use_chain     = chain && (CH_IDX > 0);
   assign pre_hit       = (pre_cnt == prescale);
   assign tick          = use_chain ? chain_in : pre_hit;
   assign timeout_event = run && tick && (cnt == '0);
   assign wr_prescale   = (PRESCALE_W > 0) ? wdata[PW-1:0] : '0;
   assign irq           = to && ito;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt      <= CNT_W'(DEFAULT_PERIOD);
         period   <= CNT_W'(DEFAULT_PERIOD);
         snap     <= '0;
         prescale <= '0;
         pre_cnt  <= '0;
         ito      <= 1'b0;
         cont     <= 1'b0;
         chain    <= 1'b0;
         to       <= 1'b0;
         run      <= 1'b0;
         pulse    <= 1'b0;
      end else begin
         pulse <= timeout_event;
         if (run && tick) begin
            if (cnt == '0) begin
               cnt <= period;
               to  <= 1'b1;
               if (!cont) run <= 1'b0;
            end else begin
               cnt <= cnt - 1'b1;
            end
         end
         if (run && !use_chain) pre_cnt <= pre_hit ? '0 : pre_cnt + 1'b1;
         // Register writes come last so they override the counting updates.
         if (wr_en) begin
            case (reg_sel)
               REG_STATUS: if (!timeout_event) to <= 1'b0;
               REG_CONTROL: begin
                  ito   <= wdata[CT_ITO];
                  cont  <= wdata[CT_CONT];
                  chain <= wdata[CT_CHAIN];
                  if (wdata[CT_START]) begin
                     run     <= 1'b1;
                     pre_cnt <= '0;
                  end else if (wdata[CT_STOP]) begin
                     run <= 1'b0;
                  end
               end
               REG_PERIOD: begin
                  period  <= wdata[CNT_W-1:0];
                  cnt     <= wdata[CNT_W-1:0];
                  run     <= 1'b0;
                  pre_cnt <= '0;
               end
               REG_SNAP:     snap     <= cnt;
               REG_PRESCALE: prescale <= wr_prescale;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (reg_sel)
         REG_STATUS: begin
            rdata[ST_TO]  = to;
            rdata[ST_RUN] = run;
         end
         REG_CONTROL: begin
            rdata[CT_ITO]   = ito;
            rdata[CT_CONT]  = cont;
            rdata[CT_CHAIN] = chain;
         end
         REG_PERIOD:   rdata = 32'(period);
         REG_SNAP:     rdata = 32'(snap);
         REG_PRESCALE: rdata = (PRESCALE_W > 0) ? 32'(prescale) : '0;
         default: ;
      endcase
   end

endmodule

// File: rtl/multi_channel_interval_timer.sv
// Avalon-MM slave with NUM_CH interval timers: address decode, registered read
// mux, channel chaining and the interrupt OR.
module multi_channel_interval_timer
   import timer_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int CNT_W          = 32,
   parameter int PRESCALE_W     = 8,
   parameter int DEFAULT_PERIOD = 39999
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [addr_w(NUM_CH)-1:0] address,
   input  logic                      chipselect,
   input  logic                      write_n,
   input  logic [31:0]               writedata,
   output logic [31:0]               readdata,
   output logic                      irq,
   output logic [NUM_CH-1:0]         irq_vec,
   output logic [NUM_CH-1:0]         pulse_out
);

   localparam int AW = addr_w(NUM_CH);

   logic [AW-1:0]              ch_sel;
   logic [NUM_CH-1:0][31:0]    rd_all;
   logic [NUM_CH-1:0]          wr_en, chain_in;
   logic [31:0]                rd_mux;

   assign ch_sel = address >> 3;

   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         assign wr_en[i] = chipselect && !write_n && (ch_sel == AW'(i));
         // Channel k ticks on channel k-1's timeout pulse when chained.
         if (i == 0) begin : g_head
            assign chain_in[i] = 1'b0;
         end else begin : g_link
            assign chain_in[i] = pulse_out[i-1];
         end
         timer_channel #(
            .CH_IDX        (i),
            .CNT_W         (CNT_W),
            .PRESCALE_W    (PRESCALE_W),
            .DEFAULT_PERIOD(DEFAULT_PERIOD)
         ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .reg_sel (address[2:0]),
            .wr_en   (wr_en[i]),
            .wdata   (writedata),
            .chain_in(chain_in[i]),
            .rdata   (rd_all[i]),
            .irq     (irq_vec[i]),
            .pulse   (pulse_out[i])
         );
      end
   endgenerate

   // Channel numbers at or above NUM_CH match nothing and read 0.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (ch_sel == AW'(i)) rd_mux = rd_all[i];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rd_mux;
   end

   assign irq = |irq_vec;

endmodule

// File: tb/tb_multi_channel_interval_timer.sv
// Self-checking bench for multi_channel_interval_timer: randomized scenarios
// compared against timeout times computed arithmetically from the register values.
module tb_multi_channel_interval_timer;
   import timer_pkg::*;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 32;
   localparam int PSW    = 8;
   localparam int DP     = 39999;
   localparam int AW     = addr_w(NUM_CH);

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [AW-1:0]     address = '0;
   logic              chipselect = 1'b0;
   logic              write_n = 1'b1;
   logic [31:0]       writedata = '0;
   logic [31:0]       readdata;
   logic              irq;
   logic [NUM_CH-1:0] irq_vec;
   logic [NUM_CH-1:0] pulse_out;

   int vecs = 0;
   int errs = 0;
   int edge_n = 0;

   multi_channel_interval_timer #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE_W(PSW), .DEFAULT_PERIOD(DP)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
      .irq_vec(irq_vec), .pulse_out(pulse_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   // Reference: a channel started at edge e0 times out first at e0+first,
   // then every per edges (per==0: one-shot). Pulse is visible after that edge.
   function automatic bit fires(input int e, input int e0, input int first, input int per);
      int d;
      d = e - e0;
      if (d < first) return 1'b0;
      if (per == 0) return d == first;
      return ((d - first) % per) == 0;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic wr(input int ch, input int r, input logic [31:0] d, output int e);
      @(negedge clk);
      address = AW'(ch * 8 + r); chipselect = 1'b1; write_n = 1'b0; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      e = edge_n;
   endtask

   // Write landing exactly on edge number 'target'.
   task automatic wr_at(input int ch, input int r, input logic [31:0] d, input int target);
      do @(negedge clk); while (edge_n < target - 1);
      address = AW'(ch * 8 + r); chipselect = 1'b1; write_n = 1'b0; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input int ch, input int r, output logic [31:0] d);
      @(negedge clk);
      address = AW'(ch * 8 + r); chipselect = 1'b0;
      @(negedge clk);
      d = readdata;
   endtask

   task automatic test_reset();
      logic [31:0] d, x;
      int e;
      do_reset();
      vecs++;
      if ({readdata, irq, irq_vec, pulse_out} !== '0) begin
         errs++;
         $display("FAIL reset_outputs rd=%h irq=%b vec=%b pulse=%b want all 0", readdata, irq, irq_vec, pulse_out);
      end
      wr(0, 5, 32'hFFFF_FFFF, e);
      for (int ch = 0; ch < NUM_CH; ch++)
         for (int r = 0; r < 8; r++) begin
            rd(ch, r, d);
            x = (r == 2) ? 32'(DP) : 32'h0;
            vecs++;
            if (d !== x) begin
               errs++;
               $display("FAIL reset_reg ch%0d r%0d got=%h want=%h", ch, r, d, x);
            end
         end
   endtask

   task automatic test_periodic();
      int p, s, t, e0, e, target;
      logic xp, xi;
      for (int it = 0; it < 3; it++) begin
         p = (it == 0) ? 3 : int'($urandom_range(1, 6));
         s = (it == 0) ? 0 : int'($urandom_range(0, 3));
         do_reset();
         wr(0, REG_PRESCALE, 32'(s), e);
         wr(0, REG_PERIOD, 32'(p), e);
         wr(0, REG_CONTROL, 32'h7, e0);
         t = (p + 1) * (s + 1);
         repeat (3 * t + 3) begin
            @(negedge clk);
            e = edge_n;
            xp = fires(e, e0, t, t);
            xi = (e - e0) >= t;
            vecs++;
            if (pulse_out !== {3'b000, xp}) begin
               errs++;
               $display("FAIL periodic_pulse p=%0d s=%0d t=%0d got=%b want=%b", p, s, e - e0, pulse_out, {3'b000, xp});
            end
            vecs++;
            if (irq !== xi) begin
               errs++;
               $display("FAIL periodic_irq p=%0d s=%0d t=%0d got=%b want=%b", p, s, e - e0, irq, xi);
            end
         end
         target = edge_n + 2;
         if (((target - e0) % t) == 0) target++;
         wr_at(0, REG_STATUS, 32'h0, target);
         vecs++;
         if (irq !== 1'b0) begin
            errs++;
            $display("FAIL irq_clear got=%b want=0", irq);
         end
      end
   endtask

   task automatic test_oneshot();
      int p, s, first, e0, e;
      logic [31:0] d;
      for (int it = 0; it < 2; it++) begin
         p = (it == 0) ? 3 : int'($urandom_range(1, 5));
         s = (it == 0) ? 1 : int'($urandom_range(0, 2));
         do_reset();
         wr(1, REG_PRESCALE, 32'(s), e);
         wr(1, REG_PERIOD, 32'(p), e);
         wr(1, REG_CONTROL, 32'h4, e0);
         first = (p + 1) * (s + 1);
         repeat (first + 6) begin
            @(negedge clk);
            e = edge_n;
            vecs++;
            if (pulse_out !== {2'b00, fires(e, e0, first, 0), 1'b0} || irq !== 1'b0) begin
               errs++;
               $display("FAIL oneshot_pulse t=%0d got=%b irq=%b want pulse=%b irq=0",
                        e - e0, pulse_out, irq, {2'b00, fires(e, e0, first, 0), 1'b0});
            end
         end
         rd(1, REG_STATUS, d);
         vecs++;
         if (d !== 32'h1) begin errs++; $display("FAIL oneshot_status got=%h want=1", d); end
         wr(1, REG_SNAP, 32'h0, e);
         rd(1, REG_SNAP, d);
         vecs++;
         if (d !== 32'(p)) begin errs++; $display("FAIL oneshot_hold got=%0d want=%0d", d, p); end
      end
   endtask

   task automatic test_chain();
      int p0, p1, t0, first1, per1, e0, e;
      logic x0, x1;
      logic [3:0] xv;
      for (int it = 0; it < 2; it++) begin
         p0 = (it == 0) ? 1 : int'($urandom_range(1, 3));
         p1 = (it == 0) ? 2 : int'($urandom_range(1, 3));
         do_reset();
         wr(0, REG_PERIOD, 32'(p0), e);
         wr(1, REG_PERIOD, 32'(p1), e);
         wr(1, REG_CONTROL, 32'h17, e);
         wr(0, REG_CONTROL, 32'h6, e0);
         t0 = p0 + 1;
         per1 = t0 * (p1 + 1);
         first1 = per1 + 1;
         repeat (first1 + 2 * per1 + 2) begin
            @(negedge clk);
            e = edge_n;
            x0 = fires(e, e0, t0, t0);
            x1 = fires(e, e0, first1, per1);
            xv = {2'b00, (e - e0) >= first1, 1'b0};
            vecs++;
            if (pulse_out !== {2'b00, x1, x0}) begin
               errs++;
               $display("FAIL chain_pulse t=%0d got=%b want=%b", e - e0, pulse_out, {2'b00, x1, x0});
            end
            vecs++;
            if (irq_vec !== xv || irq !== |xv) begin
               errs++;
               $display("FAIL chain_irq t=%0d got=%b/%b want=%b", e - e0, irq_vec, irq, xv);
            end
         end
      end
   endtask

   task automatic test_snapshot();
      int p, n, e0, e;
      logic [31:0] d, x;
      for (int it = 0; it < 2; it++) begin
         p = int'($urandom_range(50, 200));
         n = (it == 0) ? 10 : int'($urandom_range(5, 20));
         do_reset();
         wr(2, REG_PERIOD, 32'(p), e);
         wr(2, REG_CONTROL, 32'h4, e0);
         wr_at(2, REG_SNAP, 32'h0, e0 + n);
         rd(2, REG_SNAP, d);
         x = 32'(p - (n - 1));
         vecs++;
         if (d !== x) begin errs++; $display("FAIL snap_value got=%0d want=%0d", d, x); end
         address = AW'(2 * 8 + REG_PERIOD);
         vecs++;
         if (readdata !== x) begin errs++; $display("FAIL read_latency_old got=%0d want=%0d", readdata, x); end
         @(negedge clk);
         vecs++;
         if (readdata !== 32'(p)) begin errs++; $display("FAIL read_latency_new got=%0d want=%0d", readdata, p); end
      end
   endtask

   task automatic test_coincide();
      int p, e0, e, target;
      logic [31:0] d;
      p = int'($urandom_range(2, 6));
      do_reset();
      wr(3, REG_PERIOD, 32'(p), e);
      wr(3, REG_CONTROL, 32'h7, e0);
      wr_at(3, REG_STATUS, 32'h0, e0 + p + 1);
      vecs++;
      if (irq_vec[3] !== 1'b1 || pulse_out[3] !== 1'b1) begin
         errs++;
         $display("FAIL clear_vs_event irq_vec3=%b pulse3=%b want 1/1", irq_vec[3], pulse_out[3]);
      end
      target = edge_n + 2;
      if (((target - e0) % (p + 1)) == 0) target++;
      wr_at(3, REG_STATUS, 32'h0, target);
      vecs++;
      if (irq_vec[3] !== 1'b0) begin errs++; $display("FAIL status_clear got=%b want=0", irq_vec[3]); end
      wr(3, REG_PERIOD, 32'd100, e);
      wr(3, REG_CONTROL, 32'h0C, e);
      rd(3, REG_STATUS, d);
      vecs++;
      if (d[ST_RUN] !== 1'b1) begin errs++; $display("FAIL start_wins run=%b want=1", d[ST_RUN]); end
      rd(3, REG_CONTROL, d);
      vecs++;
      if (d !== 32'h0) begin errs++; $display("FAIL ctrl_strobes_read got=%h want=0", d); end
      wr(3, REG_CONTROL, 32'h8, e);
      rd(3, REG_STATUS, d);
      vecs++;
      if (d[ST_RUN] !== 1'b0) begin errs++; $display("FAIL stop run=%b want=0", d[ST_RUN]); end
      wr(3, REG_CONTROL, 32'h1F, e);
      rd(3, REG_CONTROL, d);
      vecs++;
      if (d !== 32'h13) begin errs++; $display("FAIL ctrl_readback got=%h want=13", d); end
   endtask

   task automatic test_reset_mid();
      int n, e0, e;
      logic [31:0] d;
      do_reset();
      wr(0, REG_PERIOD, 32'd50, e);
      wr(0, REG_CONTROL, 32'h7, e0);
      n = int'($urandom_range(55, 90));
      while (edge_n < e0 + n) @(negedge clk);
      vecs++;
      if (irq !== 1'b1) begin errs++; $display("FAIL pre_reset_irq got=%b want=1", irq); end
      do_reset();
      vecs++;
      if ({readdata, irq, irq_vec, pulse_out} !== '0) begin
         errs++;
         $display("FAIL midreset_outputs rd=%h irq=%b vec=%b pulse=%b want all 0", readdata, irq, irq_vec, pulse_out);
      end
      rd(0, REG_STATUS, d);
      vecs++;
      if (d !== 32'h0) begin errs++; $display("FAIL midreset_status got=%h want=0", d); end
      rd(0, REG_PERIOD, d);
      vecs++;
      if (d !== 32'(DP)) begin errs++; $display("FAIL midreset_period got=%0d want=%0d", d, DP); end
      wr(0, REG_SNAP, 32'h0, e);
      rd(0, REG_SNAP, d);
      vecs++;
      if (d !== 32'(DP)) begin errs++; $display("FAIL midreset_counter got=%0d want=%0d", d, DP); end
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_oneshot();
      test_chain();
      test_snapshot();
      test_coincide();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
